// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive-side controller.
//   clogb2          : ceiling log2, used to size counters and pointers
//   rx_ctrl_state_t : staging FSM state (EMPTY / HOLD)
//   rx_entry_t      : one buffered byte {err, last, data}
package uart_pkg;

    // Smallest n with 2**n >= value (clogb2(1) = 0).
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } rx_ctrl_state_t;

    typedef struct packed {
        logic       err;
        logic       last;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst_n  : clock, synchronous active-low reset (clears pointers/count)
//   push        : write push_data; accepted when not full or when a pop
//                 happens in the same cycle
//   pop         : consume the head; ignored while empty
//   full, count : occupancy status
//   head_data   : current head (zero while empty), head_valid = count != 0
module sync_fifo
    import uart_pkg::*;
#(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 16,
    localparam int AW    = clogb2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_en;
    logic             push_en;

    assign head_valid = (count != '0);
    assign full       = (count == CW'(DEPTH));
    assign pop_en     = pop && head_valid;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_en    = push && (!full || pop_en);

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

    assign head_data = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller between a UART receiver and a fabric consumer.
// Stages one byte, pushes it to a FIFO when the next byte arrives (last=0)
// or when the line has been idle for the message gap (last=1). Parity
// selection toward the receiver only changes between messages.
//   clk, rst_n            : clock, synchronous active-low reset
//   cfg_odd, cfg_drop_err : parity request, discard errored bytes
//   clr_status            : clears overrun and err_count
//   rx_odd                : parity select to the receiver
//   rx_dout/strobe/error/busy : receiver byte interface
//   m_data/last/err/valid, m_ready : consumer stream
//   fifo_count, overrun, err_count : status
//   dbg_state             : staging FSM state
// Consumer handshake: an entry transfers in any cycle where m_valid and
// m_ready are both 1; while m_valid=1 and m_ready=0 the head is held stable,
// and m_valid never drops without a transfer (except on reset).
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter  int CLK_FREQUENCY = 100000000,
    parameter  int BAUD_RATE     = 19200,
    parameter  int FIFO_DEPTH    = 16,
    parameter  int IDLE_BYTES    = 4,
    localparam int CW            = clogb2(FIFO_DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_odd,
    input  logic           cfg_drop_err,
    input  logic           clr_status,
    output logic           rx_odd,
    input  logic [7:0]     rx_dout,
    input  logic           rx_strobe,
    input  logic           rx_error,
    input  logic           rx_busy,
    output logic [7:0]     m_data,
    output logic           m_last,
    output logic           m_err,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [CW-1:0]  fifo_count,
    output logic           overrun,
    output logic [7:0]     err_count,
    output rx_ctrl_state_t dbg_state
);

    localparam int ONE_BIT_CNT = CLK_FREQUENCY / BAUD_RATE;
    localparam int GAP_CYCLES  = IDLE_BYTES * 11 * ONE_BIT_CNT;
    localparam int GW          = clogb2(GAP_CYCLES);

    rx_ctrl_state_t state_q;
    rx_ctrl_state_t state_d;
    logic           stage_err_q;
    logic [7:0]     stage_data_q;
    logic [GW-1:0]  gap_q;

    logic      accept;
    logic      idle_tick;
    logic      timeout;
    logic      push;
    logic      push_last;
    logic      pop;
    logic      fifo_full;
    logic      lost;
    rx_entry_t push_entry;
    rx_entry_t head;

    assign accept    = rx_strobe && !(rx_error && cfg_drop_err);
    // A dropped strobe is neither activity nor idle: the gap counter holds.
    assign idle_tick = (state_q == HOLD) && !rx_strobe && !rx_busy;
    assign timeout   = idle_tick && (gap_q == GW'(GAP_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept)  state_d = HOLD;
            HOLD:    if (timeout) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // FSM outputs: push the staged byte on a new byte or at the gap timeout
    always_comb begin
        push      = 1'b0;
        push_last = 1'b0;
        case (state_q)
            HOLD: begin
                if (accept) begin
                    push = 1'b1;
                end else if (timeout) begin
                    push      = 1'b1;
                    push_last = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign push_entry = '{err: stage_err_q, last: push_last, data: stage_data_q};

    // Staging register and idle-gap counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_err_q  <= 1'b0;
            stage_data_q <= '0;
            gap_q        <= '0;
        end else if (accept) begin
            stage_err_q  <= rx_error;
            stage_data_q <= rx_dout;
            gap_q        <= '0;
        end else if ((state_q == HOLD) && !rx_strobe) begin
            if (rx_busy || timeout) gap_q <= '0;
            else                    gap_q <= gap_q + GW'(1);
        end
    end

    assign pop  = m_valid && m_ready;
    assign lost = push && fifo_full && !pop;

    // Parity select, sticky overrun, saturating error count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_odd    <= 1'b0;
            overrun   <= 1'b0;
            err_count <= '0;
        end else begin
            if ((state_q == EMPTY) && !rx_busy) rx_odd <= cfg_odd;

            if (clr_status)  overrun <= 1'b0;
            else if (lost)   overrun <= 1'b1;

            if (clr_status)
                err_count <= '0;
            else if (rx_strobe && rx_error && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .full       (fifo_full),
        .count      (fifo_count),
        .head_data  (head),
        .head_valid (m_valid)
    );

    assign m_data    = head.data;
    assign m_last    = head.last;
    assign m_err     = head.err;
    assign dbg_state = state_q;

endmodule
